btn_conditioner: RTL

//  Input-side conditioner for board push-buttons (BTNL/BTNC/BTNR -> start/stop/clear).

---
 rtl/btn_conditioner_if.sv | 23 ++
 rtl/btn_conditioner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw pins in, debounced level and pulses out.
interface btn_conditioner_if #(
   parameter int N_BTN = 3
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release
   );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button synchroniser + per-bit debouncer with press/release pulses.
// Optional auto-repeat of btn_press while held: define BTN_REPEAT_EN.
module btn_conditioner #(
   parameter int N_BTN         = 3,
   parameter int DB_CYCLES     = 2_000_000,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic               clk,
   input  logic               reset_n,
   btn_conditioner_if.slave   bus
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   if (DB_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("btn_conditioner: illegal cycle parameters");
   end

   typedef enum logic {IDLE, PRESSED} state_e;

   state_e           st_q  [N_BTN];
   state_e           st_d  [N_BTN];
   logic [CW-1:0]    cnt_q [N_BTN];
   logic [CW-1:0]    cnt_d [N_BTN];
   logic [N_BTN-1:0] s1_q, s2_q;
   logic [N_BTN-1:0] press_q, press_d;
   logic [N_BTN-1:0] rel_q, rel_d;
   logic [N_BTN-1:0] level;

`ifdef BTN_REPEAT_EN
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW = $clog2(HMAX + 1);
   localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

   logic [HW-1:0]    hold_q [N_BTN];
   logic [HW-1:0]    hold_d [N_BTN];
   logic [N_BTN-1:0] rep_q, rep_d;
`endif

   always_comb begin
      for (int i = 0; i < N_BTN; i++) begin
         st_d[i]    = st_q[i];
         cnt_d[i]   = cnt_q[i];
         press_d[i] = 1'b0;
         rel_d[i]   = 1'b0;
`ifdef BTN_REPEAT_EN
         hold_d[i]  = hold_q[i];
         rep_d[i]   = rep_q[i];
`endif
         unique case (st_q[i])
            IDLE: begin
               if (s2_q[i]) begin
                  if (cnt_q[i] == DB_LAST) begin
                     st_d[i]    = PRESSED;
                     cnt_d[i]   = '0;
                     press_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end else begin
                  cnt_d[i] = '0;
               end
`ifdef BTN_REPEAT_EN
               hold_d[i] = '0;
               rep_d[i]  = 1'b0;
`endif
            end
            PRESSED: begin
               if (!s2_q[i]) begin
                  if (cnt_q[i] == DB_LAST) begin
                     st_d[i]  = IDLE;
                     cnt_d[i] = '0;
                     rel_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end else begin
                  cnt_d[i] = '0;
               end
`ifdef BTN_REPEAT_EN
               // First repeat waits HOLD, later ones REPEAT; any low sample restarts
               if (!s2_q[i]) begin
                  hold_d[i] = '0;
                  rep_d[i]  = 1'b0;
               end else if (hold_q[i] == (rep_q[i] ? R_LAST : H_LAST)) begin
                  hold_d[i]  = '0;
                  rep_d[i]   = 1'b1;
                  press_d[i] = 1'b1;
               end else begin
                  hold_d[i] = hold_q[i] + HW'(1);
               end
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_q    <= '0;
         s2_q    <= '0;
         press_q <= '0;
         rel_q   <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q    <= bus.btn_raw;
         s2_q    <= s1_q;
         press_q <= press_d;
         rel_q   <= rel_d;
         for (int i = 0; i < N_BTN; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

`ifdef BTN_REPEAT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rep_q <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            hold_q[i] <= '0;
         end
      end else begin
         rep_q <= rep_d;
         for (int i = 0; i < N_BTN; i++) begin
            hold_q[i] <= hold_d[i];
         end
      end
   end
`endif

   always_comb begin
      level = '0;
      for (int i = 0; i < N_BTN; i++) begin
         level[i] = (st_q[i] == PRESSED);
      end
   end

   assign bus.btn_level   = level;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = rel_q;

endmodule
